// File: rtl/trng_entropy_arbiter_if.sv
// Bus bundle for trng_entropy_arbiter: source-side syn/data/ack lanes,
// mixer-side syn/data/ack, the enables and the status flags.
// master = the side that drives the sources/mixer, slave = the arbiter.
interface trng_entropy_arbiter_if #(
  parameter int NUM_SRC = 3
);
  logic                   enable;
  logic [NUM_SRC-1:0]     src_enable;
  logic [NUM_SRC-1:0]     src_syn;
  logic [32*NUM_SRC-1:0]  src_data;
  logic [NUM_SRC-1:0]     src_ack;
  logic                   out_syn;
  logic [31:0]            out_data;
  logic [1:0]             out_src_id;
  logic                   out_ack;
  logic                   busy;
  logic [NUM_SRC-1:0]     src_fault;

  modport master (
    output enable, src_enable, src_syn, src_data, out_ack,
    input  src_ack, out_syn, out_data, out_src_id, busy, src_fault
  );

  modport slave (
    input  enable, src_enable, src_syn, src_data, out_ack,
    output src_ack, out_syn, out_data, out_src_id, busy, src_fault
  );
endinterface

// File: rtl/trng_entropy_arbiter.sv
// trng_entropy_arbiter: round-robin arbiter sharing one TRNG mixer among
// NUM_SRC entropy sources. One word is taken from the next ready, enabled
// source after the last winner, that source is acked with a one-cycle
// pulse, and the word is presented with its source id until the mixer acks.
// Optional starvation watchdog: define TRNG_ENTROPY_ARB_TIMEOUT_EN to build
// per-source idle counters that fault sources silent for TIMEOUT cycles.
module trng_entropy_arbiter #(
  parameter int          NUM_SRC = 3,
  parameter logic [15:0] TIMEOUT = 16'h1000
) (
  input logic                   clk,
  input logic                   reset,
  trng_entropy_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SELECT  = 2'd1,
    PRESENT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic               out_syn_q, out_syn_d;
  logic [31:0]        out_data_q, out_data_d;
  logic [1:0]         out_src_id_q, out_src_id_d;
  logic [NUM_SRC-1:0] src_ack_q, src_ack_d;
  logic               busy_q, busy_d;

  logic [NUM_SRC-1:0] fault_s;
  logic [NUM_SRC-1:0] cand_s;
  logic               hit_s;
  logic [1:0]         winner_s;
  logic [31:0]        sel_data_s;
  logic [NUM_SRC-1:0] ack_vec_s;

  // Source index reached by stepping 'step' places past ptr, modulo NUM_SRC.
  function automatic logic [1:0] rr_index(input logic [1:0] ptr, input int step);
    int idx;
    idx = int'(ptr) + step;
    if (idx >= NUM_SRC) begin
      idx = idx - NUM_SRC;
    end else begin
      idx = idx;
    end
    return idx[1:0];
  endfunction

  assign cand_s = bus.src_enable & bus.src_syn & ~fault_s;

  // Round-robin search: first candidate after the previous winner.
  always_comb begin
    hit_s    = 1'b0;
    winner_s = 2'd0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (!hit_s && cand_s[rr_index(rr_ptr_q, k)]) begin
        hit_s    = 1'b1;
        winner_s = rr_index(rr_ptr_q, k);
      end else begin
        hit_s    = hit_s;
      end
    end
  end

  // Select the winner's word and build its one-hot ack.
  always_comb begin
    sel_data_s = 32'd0;
    ack_vec_s  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (winner_s == i[1:0]) begin
        sel_data_s   = bus.src_data[32*i +: 32];
        ack_vec_s[i] = 1'b1;
      end else begin
        ack_vec_s[i] = 1'b0;
      end
    end
  end

  // FSM next state and next values of every registered output.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    out_syn_d    = out_syn_q;
    out_data_d   = out_data_q;
    out_src_id_d = out_src_id_q;
    src_ack_d    = '0;
    if (!bus.enable) begin
      // Global disable wins over everything; a pending word is dropped.
      state_d   = IDLE;
      out_syn_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SELECT;
        end
        SELECT: begin
          if (hit_s) begin
            state_d      = PRESENT;
            out_syn_d    = 1'b1;
            out_data_d   = sel_data_s;
            out_src_id_d = winner_s;
            src_ack_d    = ack_vec_s;
          end else begin
            state_d = SELECT;
          end
        end
        PRESENT: begin
          if (bus.out_ack) begin
            out_syn_d = 1'b0;
            rr_ptr_d  = out_src_id_q;
            state_d   = SELECT;
          end else begin
            state_d = PRESENT;
          end
        end
        default: begin
          state_d   = IDLE;
          out_syn_d = 1'b0;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= 2'(NUM_SRC - 1);
      out_syn_q    <= 1'b0;
      out_data_q   <= 32'd0;
      out_src_id_q <= 2'd0;
      src_ack_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      out_syn_q    <= out_syn_d;
      out_data_q   <= out_data_d;
      out_src_id_q <= out_src_id_d;
      src_ack_q    <= src_ack_d;
      busy_q       <= busy_d;
    end
  end

`ifdef TRNG_ENTROPY_ARB_TIMEOUT_EN
  logic [15:0]        cnt_q [NUM_SRC];
  logic [15:0]        cnt_d [NUM_SRC];
  logic [NUM_SRC-1:0] fault_q, fault_d;

  // Idle counters: clear on ack or disable, count while enabled, saturate.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      cnt_d[i]   = cnt_q[i];
      fault_d[i] = fault_q[i];
      if (!bus.src_enable[i]) begin
        cnt_d[i]   = 16'd0;
        fault_d[i] = 1'b0;
      end else if (src_ack_d[i]) begin
        cnt_d[i]   = 16'd0;
      end else if (bus.enable) begin
        if (cnt_q[i] >= TIMEOUT) begin
          cnt_d[i] = TIMEOUT;
        end else begin
          cnt_d[i] = cnt_q[i] + 16'd1;
        end
        if (cnt_d[i] == TIMEOUT) begin
          fault_d[i] = 1'b1;
        end else begin
          fault_d[i] = fault_q[i];
        end
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Watchdog counter and sticky fault registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        cnt_q[i] <= 16'd0;
      end
      fault_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      fault_q <= fault_d;
    end
  end

  assign fault_s = fault_q;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = ^TIMEOUT;
  assign fault_s          = '0;
`endif

  assign bus.src_ack    = src_ack_q;
  assign bus.out_syn    = out_syn_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_src_id = out_src_id_q;
  assign bus.busy       = busy_q;
  assign bus.src_fault  = fault_s;

endmodule
